// File: rtl/axis_pin_packetizer_pkg.sv
// Shared constants for the pin packetizer: default geometry, overflow counter
// width, AXI-Stream sideband tie-offs and a saturating increment helper.
package axis_pin_packetizer_pkg;

    localparam int DEF_PIN_W      = 8;
    localparam int DEF_LANES      = 4;
    localparam int DEF_DEPTH_LOG2 = 4;
    localparam int DEF_PKT_W      = 16;
    localparam int OVF_CNT_W      = 16;

    localparam logic [7:0] TID_TIE   = 8'h00;
    localparam logic [1:0] TDEST_TIE = 2'b00;

    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with occupancy output; head entry is read combinationally
// so it stays put until a read is accepted.
module axis_sync_fifo #(
    parameter int WIDTH      = 33,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  do_wr, do_rd;

    // Level never exceeds DEPTH, so its MSB alone marks full.
    assign full    = level_q[DEPTH_LOG2];
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/axis_pin_packetizer.sv
// Packs LANES pin samples into one word, frames words into packets of
// cfg_pkt_len with TLAST, and buffers them toward an AXI4-Stream master.
module axis_pin_packetizer
    import axis_pin_packetizer_pkg::*;
#(
    parameter int PIN_W      = DEF_PIN_W,
    parameter int LANES      = DEF_LANES,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int PKT_W      = DEF_PKT_W
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [PIN_W-1:0]         data_pins,
    input  logic                     pin_valid,
    input  logic                     cfg_enable,
    input  logic [PKT_W-1:0]         cfg_pkt_len,
    input  logic                     clr_status,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [PIN_W*LANES-1:0]   m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic [PIN_W*LANES/8-1:0] m_axis_tkeep,
    output logic [PIN_W*LANES/8-1:0] m_axis_tstrb,
    output logic [7:0]               m_axis_tid,
    output logic [1:0]               m_axis_tdest,
    output logic [DEPTH_LOG2:0]      fifo_level,
    output logic [OVF_CNT_W-1:0]     overflow_cnt,
    output logic                     overflow_flag
);

    localparam int DATA_W = PIN_W * LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [DATA_W-1:0]    acc_q, acc_d, word;
    logic [PKT_W-1:0]     pkt_cnt_q, pkt_cnt_d, len_q, len_d, eff_len;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic                 ovf_flag_q, ovf_flag_d;
    logic                 capture, final_lane, wr_en, wr_last, drop;
    logic                 fifo_full, fifo_empty;
    logic [DATA_W:0]      head;

    assign capture    = pin_valid && cfg_enable;
    assign final_lane = capture && (lane_q == LANE_W'(LANES - 1));
    assign wr_en      = final_lane && !fifo_full;
    assign drop       = final_lane && fifo_full;

    // Length is sampled at each packet start; mid-packet cfg changes wait.
    assign eff_len = (pkt_cnt_q == '0) ? cfg_pkt_len : len_q;
    assign wr_last = (eff_len != '0) && (pkt_cnt_q == eff_len - 1'b1);

    always_comb begin
        word = acc_q;
        word[lane_q*PIN_W +: PIN_W] = data_pins;

        lane_d = lane_q;
        acc_d  = acc_q;
        if (!cfg_enable) begin
            lane_d = '0;
        end else if (capture) begin
            acc_d  = word;
            lane_d = final_lane ? '0 : lane_q + 1'b1;
        end

        len_d     = eff_len;
        pkt_cnt_d = pkt_cnt_q;
        if (wr_en) pkt_cnt_d = (eff_len == '0 || wr_last) ? '0 : pkt_cnt_q + 1'b1;

        ovf_cnt_d  = drop ? sat_inc(ovf_cnt_q) : ovf_cnt_q;
        ovf_flag_d = ovf_flag_q || drop;
        if (clr_status) begin
            ovf_cnt_d  = drop ? OVF_CNT_W'(1) : '0;
            ovf_flag_d = drop;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            lane_q     <= '0;
            acc_q      <= '0;
            pkt_cnt_q  <= '0;
            len_q      <= '0;
            ovf_cnt_q  <= '0;
            ovf_flag_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            acc_q      <= acc_d;
            pkt_cnt_q  <= pkt_cnt_d;
            len_q      <= len_d;
            ovf_cnt_q  <= ovf_cnt_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    axis_sync_fifo #(
        .WIDTH      (DATA_W + 1),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .wr_en   (wr_en),
        .wr_data ({wr_last, word}),
        .full    (fifo_full),
        .rd_en   (m_axis_tvalid && m_axis_tready),
        .rd_data (head),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = head[DATA_W-1:0];
    assign m_axis_tlast  = !fifo_empty && head[DATA_W];
    assign m_axis_tkeep  = '1;
    assign m_axis_tstrb  = '1;
    assign m_axis_tid    = TID_TIE;
    assign m_axis_tdest  = TDEST_TIE;
    assign overflow_cnt  = ovf_cnt_q;
    assign overflow_flag = ovf_flag_q;

endmodule

// File: tb/tb_axis_pin_packetizer.sv
// Directed bench: stimulus pushes expected beats into a queue, a negedge
// monitor pops and compares each accepted beat.
module tb_axis_pin_packetizer;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  data_pins = '0;
    logic        pin_valid = 1'b0;
    logic        cfg_enable = 1'b1;
    logic [15:0] cfg_pkt_len = '0;
    logic        clr_status = 1'b0;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep, m_axis_tstrb;
    logic [7:0]  m_axis_tid;
    logic [1:0]  m_axis_tdest;
    logic [4:0]  fifo_level;
    logic [15:0] overflow_cnt;
    logic        overflow_flag;

    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axis_pin_packetizer dut (
        .aclk(aclk), .areset(areset), .data_pins(data_pins), .pin_valid(pin_valid),
        .cfg_enable(cfg_enable), .cfg_pkt_len(cfg_pkt_len), .clr_status(clr_status),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
        .fifo_level(fifo_level), .overflow_cnt(overflow_cnt), .overflow_flag(overflow_flag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got 0x%0h expected none", m_axis_tdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", m_axis_tdata, mon_e[31:0]);
                chk("beat_last", 32'(m_axis_tlast), 32'(mon_e[32]));
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic samp(input logic [7:0] d, input logic clr);
        data_pins  = d;
        pin_valid  = 1'b1;
        clr_status = clr;
        @(posedge aclk); #1;
        pin_valid  = 1'b0;
        clr_status = 1'b0;
    endtask

    task automatic word(input logic [7:0] k, input logic lst, input logic wr, input logic clr);
        logic [31:0] d;
        d = {k + 8'hC0, k + 8'h80, k + 8'h40, k};
        samp(k, 1'b0);
        samp(k + 8'h40, 1'b0);
        samp(k + 8'h80, 1'b0);
        if (wr) exp_q.push_back({lst, d});
        samp(k + 8'hC0, clr);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 300) begin
            @(posedge aclk); #1;
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        m_axis_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_tlast", 32'(m_axis_tlast), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ovf_cnt", 32'(overflow_cnt), 0);
        chk("rst_ovf_flag", 32'(overflow_flag), 0);
        chk("tkeep", 32'(m_axis_tkeep), 32'hF);
        chk("tstrb", 32'(m_axis_tstrb), 32'hF);
        chk("tid_tdest", 32'({m_axis_tid, m_axis_tdest}), 0);
        areset = 1'b0;

        // Basic packing and one-cycle latency
        m_axis_tready = 1'b1;
        @(posedge aclk); #1;
        samp(8'h11, 1'b0);
        samp(8'h22, 1'b0);
        samp(8'h33, 1'b0);
        chk("lat_before", 32'(m_axis_tvalid), 0);
        exp_q.push_back({1'b0, 32'h44332211});
        samp(8'h44, 1'b0);
        chk("lat_after", 32'(m_axis_tvalid), 1);
        chk("lat_data", m_axis_tdata, 32'h44332211);
        wait_drain();

        // Packet length 3, switched to 2 mid-packet after word 4
        cfg_pkt_len = 16'd3;
        for (int i = 1; i <= 4; i++) word(8'(i), (i % 3) == 0, 1'b1, 1'b0);
        cfg_pkt_len = 16'd2;
        word(8'd5, 1'b0, 1'b1, 1'b0);
        word(8'd6, 1'b1, 1'b1, 1'b0);
        word(8'd7, 1'b0, 1'b1, 1'b0);
        word(8'd8, 1'b1, 1'b1, 1'b0);
        word(8'd9, 1'b0, 1'b1, 1'b0);
        word(8'd10, 1'b1, 1'b1, 1'b0);
        wait_drain();

        // Overflow: 18 words into a 16-deep FIFO, pkt_len 4
        cfg_pkt_len = 16'd4;
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 18; i++)
            word(8'(8'h10 + i), (i <= 16) && (i % 4 == 0), i <= 16, 1'b0);
        chk("ovf_level", 32'(fifo_level), 16);
        chk("ovf_cnt", 32'(overflow_cnt), 2);
        chk("ovf_flag", 32'(overflow_flag), 1);
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 4; i++) word(8'(8'h30 + i), i == 4, 1'b1, 1'b0);
        wait_drain();
        chk("drained_level", 32'(fifo_level), 0);

        // Status clear alone, then clear coincident with a drop
        clr_status = 1'b1;
        @(posedge aclk); #1;
        clr_status = 1'b0;
        chk("clr_cnt", 32'(overflow_cnt), 0);
        chk("clr_flag", 32'(overflow_flag), 0);
        cfg_pkt_len = 16'd0;
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 16; i++) word(8'(8'h50 + i), 1'b0, 1'b1, 1'b0);
        word(8'h70, 1'b0, 1'b0, 1'b1);
        chk("clr_drop_cnt", 32'(overflow_cnt), 1);
        chk("clr_drop_flag", 32'(overflow_flag), 1);
        m_axis_tready = 1'b1;
        wait_drain();

        // Disable discards a partial word
        samp(8'hA1, 1'b0);
        samp(8'hA2, 1'b0);
        cfg_enable = 1'b0;
        @(posedge aclk); #1;
        cfg_enable = 1'b1;
        samp(8'h01, 1'b0);
        samp(8'h02, 1'b0);
        samp(8'h03, 1'b0);
        exp_q.push_back({1'b0, 32'h04030201});
        samp(8'h04, 1'b0);
        wait_drain();

        // Reset mid-packet with 5 queued words and a partial word
        cfg_pkt_len = 16'd3;
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 5; i++) word(8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        samp(8'hEE, 1'b0);
        samp(8'hEF, 1'b0);
        chk("pre_rst_level", 32'(fifo_level), 5);
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        chk("post_rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("post_rst_level", 32'(fifo_level), 0);
        chk("post_rst_ovf", 32'(overflow_cnt), 0);
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 3; i++) word(8'(8'h90 + i), i == 3, 1'b1, 1'b0);
        wait_drain();

        repeat (3) @(posedge aclk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_pin_packetizer.md
AXIS_PIN_PACKETIZER -- requirements
Module: axis_pin_packetizer

Interface
REQ-001 Parameter PIN_W, default 8: width of the parallel input pin bus.
REQ-002 Parameter LANES, default 4: pin samples per output word; DATA_W = PIN_W*LANES.
REQ-003 Parameter DEPTH_LOG2, default 4: FIFO depth 2^DEPTH_LOG2 words.
REQ-004 Parameter PKT_W, default 16: width of the packet-length field.
REQ-005 aclk  in  1  single clock; all logic on rising edge.
REQ-006 areset  in  1  reset, synchronous, active-high.
REQ-007 data_pins  in  PIN_W  sampled input data.
REQ-008 pin_valid  in  1  sample strobe; data_pins captured only when high.
REQ-009 cfg_enable  in  1  capture enable.
REQ-010 cfg_pkt_len  in  PKT_W  words per packet; 0 = continuous stream, TLAST never set.
REQ-011 clr_status  in  1  one-cycle pulse clearing overflow status.
REQ-012 m_axis_tvalid/tready/tdata[DATA_W]/tlast  AXI4-Stream master.
REQ-013 m_axis_tkeep, m_axis_tstrb  out  DATA_W/8  tied all-ones; m_axis_tid out 8 and m_axis_tdest out 2 tied zero.
REQ-014 fifo_level  out  DEPTH_LOG2+1  current FIFO occupancy.
REQ-015 overflow_cnt  out  16  saturating count of dropped words.
REQ-016 overflow_flag  out  1  sticky; set on any drop.

Function
REQ-017 Lane counter advances only on cycles with pin_valid && cfg_enable; first sample lands in tdata[PIN_W-1:0], the LANES-th in the MSBs.
REQ-018 On the edge capturing the final lane, the assembled word (accumulator plus current data_pins) SHALL be written to the FIFO the same edge if the FIFO is not full.
REQ-019 Latency: m_axis_tvalid high in the cycle immediately after the final-lane edge, given an empty FIFO.
REQ-020 If the FIFO is full at the final-lane edge, the word is dropped, overflow_cnt increments (saturating at 0xFFFF), overflow_flag sets; the lane counter still wraps to 0 (no stall).
REQ-021 Write is blocked when full even if a read occurs the same cycle; simultaneous read and write on a non-full, non-empty FIFO leaves fifo_level unchanged.
REQ-022 m_axis_tvalid = (fifo_level != 0), combinational from registered state; tdata/tlast driven from the head entry.
REQ-023 Head entry SHALL remain stable while tvalid && !tready.
REQ-024 Read pointer, write pointer, and word counter wrap modulo their ranges; no intermediate value is lost.
REQ-025 Each FIFO entry stores DATA_W data bits plus 1 tlast bit.
REQ-026 Packet word counter counts words actually written; dropped words do not advance it.
REQ-027 tlast stored as 1 when counter == latched_len-1, then counter returns to 0.
REQ-028 latched_len loads from cfg_pkt_len when counter == 0; mid-packet changes take effect on the next packet.
REQ-029 latched_len == 0: tlast 0 always, counter held at 0.
REQ-030 latched_len == 1: every word carries tlast=1.
REQ-031 cfg_enable low clears the lane counter and discards any partial word; the FIFO and packet counter are unaffected, and the FIFO continues draining.
REQ-032 clr_status zeroes overflow_cnt and overflow_flag; a drop in the same cycle wins: count = 1, flag = 1.

Reset
REQ-033 areset high at a clock edge SHALL clear: pointers, fifo_level, lane counter, accumulator, packet counter, latched_len, overflow_cnt, overflow_flag.
REQ-034 During and after reset, m_axis_tvalid = 0 and tlast = 0; FIFO memory contents need no reset.
REQ-035 Reset mid-packet or mid-word discards all buffered data; the next packet starts at word 0.

Structure
REQ-036 A shared package SHALL hold default parameter constants, the overflow counter width (16), and the tid/tdest tie-off constants.
REQ-037 The FIFO SHALL be a sub-module axis_sync_fifo (width, depth parameters; wr_en/full, rd_en/empty, level).
REQ-038 Lane assembly and packet counting SHALL live in the top module.

Verification
REQ-039 PIN_W=8, LANES=4, tready=1, pins 0x11,0x22,0x33,0x44 on 4 strobes -> one beat tdata=0x44332211, tvalid exactly one cycle after the 4th strobe.
REQ-040 pkt_len=3, 9 words, tready=1 -> tlast on words 3, 6, 9 only; change pkt_len to 2 after word 4 -> word 6 still last, then every 2nd word.
REQ-041 tready=0, 18 words in at depth 16 -> fifo_level=16, overflow_cnt=2, flag=1; then tready=1 -> 16 words out in order, none corrupted.
REQ-042 Drop with pkt_len=4 -> tlast still on every 4th delivered word.
REQ-043 cfg_enable low after 2 lanes, then 4 new strobes -> single word containing only the new 4 samples.
REQ-044 areset mid-packet with 5 words queued -> tvalid low the next cycle, fifo_level=0, next delivered tlast after pkt_len fresh words; clr_status coincident with a drop -> overflow_cnt=1.
